// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm sequencing controller:
// state encoding, time field widths and song select width.
package alarm_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } state_t;

endpackage

// File: rtl/alarm_match.sv
// Combinational alarm-time comparator producing the one-cycle trigger.
// Ports: i_tick, i_en, i_cur_hour/min/sec, i_alm_hour/min -> o_trig.
module alarm_match
    import alarm_pkg::*;
(
    input  logic              i_tick,
    input  logic              i_en,
    input  logic [HOUR_W-1:0] i_cur_hour,
    input  logic [MIN_W-1:0]  i_cur_min,
    input  logic [SEC_W-1:0]  i_cur_sec,
    input  logic [HOUR_W-1:0] i_alm_hour,
    input  logic [MIN_W-1:0]  i_alm_min,
    output logic              o_trig
);

    // Only second zero qualifies, so a matching minute fires once.
    assign o_trig = i_tick & i_en
                  & (i_cur_hour == i_alm_hour)
                  & (i_cur_min  == i_alm_min)
                  & (i_cur_sec  == '0);

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencing FSM: ring, stop, bounded snooze, ring timeout.
// Ports: clk, rst, tick_1hz, time/alarm fields, alarm_en, stop_btn,
// snooze_btn, sel_in -> alarm, sel, state, snoozes_left (all registered).
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter  int SNOOZE_S       = 540,
    parameter  int RING_TIMEOUT_S = 300,
    parameter  int MAX_SNOOZE     = 3,
    localparam int SL_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic [HOUR_W-1:0] alm_hour,
    input  logic [MIN_W-1:0]  alm_min,
    input  logic              alarm_en,
    input  logic              stop_btn,
    input  logic              snooze_btn,
    input  logic [SEL_W-1:0]  sel_in,
    output logic              alarm,
    output logic [SEL_W-1:0]  sel,
    output logic [1:0]        state,
    output logic [SL_W-1:0]   snoozes_left
);

    localparam int RC_W = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;
    localparam int SC_W = $clog2(SNOOZE_S + 1);

    localparam logic [RC_W-1:0] RING_LAST  = RC_W'(RING_TIMEOUT_S - 1);
    localparam logic [SC_W-1:0] SNZ_LOAD   = SC_W'(SNOOZE_S);
    localparam logic [SC_W-1:0] SNZ_LAST   = SC_W'(1);
    localparam logic [SL_W-1:0] LEFT_INIT  = SL_W'(MAX_SNOOZE);

    state_t            r_state,      w_state_nxt;
    logic [RC_W-1:0]   r_ring_cnt,   w_ring_nxt;
    logic [SC_W-1:0]   r_snooze_cnt, w_snooze_nxt;
    logic [SL_W-1:0]   r_left,       w_left_nxt;
    logic [SEL_W-1:0]  r_sel,        w_sel_nxt;
    logic              r_alarm;
    logic              w_trig;
    logic              w_abort;

    alarm_match u_match (
        .i_tick     (tick_1hz),
        .i_en       (alarm_en),
        .i_cur_hour (cur_hour),
        .i_cur_min  (cur_min),
        .i_cur_sec  (cur_sec),
        .i_alm_hour (alm_hour),
        .i_alm_min  (alm_min),
        .o_trig     (w_trig)
    );

    assign w_abort = stop_btn | ~alarm_en;

    always_comb begin
        w_state_nxt  = r_state;
        w_ring_nxt   = r_ring_cnt;
        w_snooze_nxt = r_snooze_cnt;
        w_left_nxt   = r_left;
        w_sel_nxt    = r_sel;
        case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_state_nxt = RINGING;
                    w_ring_nxt  = '0;
                    w_left_nxt  = LEFT_INIT;
                    w_sel_nxt   = sel_in;
                end
            end
            RINGING: begin
                // Stop/enable-drop beats snooze, which beats timeout.
                if (w_abort) begin
                    w_state_nxt = IDLE;
                end else if (snooze_btn && (r_left != '0)) begin
                    w_state_nxt  = SNOOZED;
                    w_snooze_nxt = SNZ_LOAD;
                    w_left_nxt   = r_left - 1'b1;
                end else if (tick_1hz) begin
                    if (r_ring_cnt == RING_LAST) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_ring_nxt = r_ring_cnt + 1'b1;
                    end
                end
            end
            SNOOZED: begin
                if (w_abort) begin
                    w_state_nxt = IDLE;
                end else if (tick_1hz) begin
                    if (r_snooze_cnt == SNZ_LAST) begin
                        w_state_nxt = RINGING;
                        w_ring_nxt  = '0;
                        w_sel_nxt   = sel_in;
                    end else begin
                        w_snooze_nxt = r_snooze_cnt - 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ring_cnt   <= '0;
            r_snooze_cnt <= '0;
            r_left       <= '0;
            r_sel        <= '0;
            r_alarm      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ring_cnt   <= w_ring_nxt;
            r_snooze_cnt <= w_snooze_nxt;
            r_left       <= w_left_nxt;
            r_sel        <= w_sel_nxt;
            r_alarm      <= (w_state_nxt == RINGING);
        end
    end

    assign alarm        = r_alarm;
    assign sel          = r_sel;
    assign state        = r_state;
    assign snoozes_left = r_left;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: vector table, reset sequence,
// and randomized traffic against a behavioural reference model.
module tb_alarm_ctrl;
    import alarm_pkg::*;

    localparam int SN = 3;
    localparam int TO = 5;
    localparam int MX = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              tick_1hz;
    logic [HOUR_W-1:0] cur_hour;
    logic [MIN_W-1:0]  cur_min;
    logic [SEC_W-1:0]  cur_sec;
    logic [HOUR_W-1:0] alm_hour;
    logic [MIN_W-1:0]  alm_min;
    logic              alarm_en;
    logic              stop_btn;
    logic              snooze_btn;
    logic [SEL_W-1:0]  sel_in;
    logic              alarm;
    logic [SEL_W-1:0]  sel;
    logic [1:0]        state;
    logic [0:0]        snoozes_left;

    alarm_ctrl #(
        .SNOOZE_S       (SN),
        .RING_TIMEOUT_S (TO),
        .MAX_SNOOZE     (MX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1hz     (tick_1hz),
        .cur_hour     (cur_hour),
        .cur_min      (cur_min),
        .cur_sec      (cur_sec),
        .alm_hour     (alm_hour),
        .alm_min      (alm_min),
        .alarm_en     (alarm_en),
        .stop_btn     (stop_btn),
        .snooze_btn   (snooze_btn),
        .sel_in       (sel_in),
        .alarm        (alarm),
        .sel          (sel),
        .state        (state),
        .snoozes_left (snoozes_left)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit tick, en, stop, snz;
        int h, m, s, si;
        int ea, est, esel, eleft;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit tick, bit en, bit stop, bit snz,
                                int h, int m, int s, int si,
                                int ea, int est, int esel, int el);
        vec_t v;
        v.tick = tick; v.en = en; v.stop = stop; v.snz = snz;
        v.h = h; v.m = m; v.s = s; v.si = si;
        v.ea = ea; v.est = est; v.esel = esel; v.eleft = el;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(string tag, int ea, int est, int esel, int el);
        chk({tag, " alarm"}, int'(alarm), ea);
        chk({tag, " state"}, int'(state), est);
        chk({tag, " sel"},   int'(sel), esel);
        chk({tag, " left"},  int'(snoozes_left), el);
    endtask

    task automatic drive(bit tick, bit en, bit stop, bit snz,
                         int h, int m, int s, int si);
        tick_1hz   = tick;
        alarm_en   = en;
        stop_btn   = stop;
        snooze_btn = snz;
        cur_hour   = HOUR_W'(h);
        cur_min    = MIN_W'(m);
        cur_sec    = SEC_W'(s);
        sel_in     = SEL_W'(si);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: elapsed ticks counted upward, phase 0/1/2.
    int m_ph, m_rung, m_slept, m_left, m_sel;

    task automatic model_reset();
        m_ph = 0; m_rung = 0; m_slept = 0; m_left = 0; m_sel = 0;
    endtask

    task automatic model_step();
        bit hit;
        bit quit;
        hit = tick_1hz && alarm_en && cur_hour == alm_hour
              && cur_min == alm_min && cur_sec == 0;
        quit = stop_btn || !alarm_en;
        if (m_ph == 0) begin
            if (hit) begin
                m_ph = 1; m_rung = 0; m_left = MX; m_sel = int'(sel_in);
            end
        end else if (m_ph == 1) begin
            if (quit) m_ph = 0;
            else if (snooze_btn && m_left > 0) begin
                m_ph = 2; m_slept = 0; m_left = m_left - 1;
            end else if (tick_1hz) begin
                m_rung = m_rung + 1;
                if (m_rung == TO) m_ph = 0;
            end
        end else begin
            if (quit) m_ph = 0;
            else if (tick_1hz) begin
                m_slept = m_slept + 1;
                if (m_slept == SN) begin
                    m_ph = 1; m_rung = 0; m_sel = int'(sel_in);
                end
            end
        end
    endtask

    initial begin
        alm_hour = 5'd7;
        alm_min  = 6'd30;
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        step();
        chk_all("reset", 0, 0, 0, 0);
        rst = 1'b0;

        // trigger / stop / no retrigger
        vq.push_back(mk(1,1,0,0, 7,29,59,1, 0,0,0,0));
        vq.push_back(mk(1,1,0,0, 7,30, 0,2, 1,1,2,1));
        vq.push_back(mk(0,1,0,0, 7,30, 0,3, 1,1,2,1));
        vq.push_back(mk(0,1,1,0, 7,30, 0,3, 0,0,2,1));
        vq.push_back(mk(1,1,0,0, 7,30, 1,3, 0,0,2,1));
        // timeout after 5 ticks
        vq.push_back(mk(1,1,0,0, 7,30, 0,1, 1,1,1,1));
        for (int i = 1; i <= 4; i++)
            vq.push_back(mk(1,1,0,0, 7,30, i,0, 1,1,1,1));
        vq.push_back(mk(1,1,0,0, 7,30, 5,0, 0,0,1,1));
        // snooze, re-ring with re-latched sel, extra snooze ignored
        vq.push_back(mk(1,1,0,0, 7,30, 0,0, 1,1,0,1));
        vq.push_back(mk(0,1,0,1, 7,30, 1,3, 0,2,0,0));
        vq.push_back(mk(1,1,0,0, 7,30, 2,3, 0,2,0,0));
        vq.push_back(mk(1,1,0,1, 7,30, 3,3, 0,2,0,0));
        vq.push_back(mk(1,1,0,0, 7,30, 4,3, 1,1,3,0));
        vq.push_back(mk(0,1,0,1, 7,30, 4,2, 1,1,3,0));
        vq.push_back(mk(1,1,1,1, 7,30, 5,2, 0,0,3,0));
        // stop+snooze+tick together with a snooze still available
        vq.push_back(mk(1,1,0,0, 7,30, 0,2, 1,1,2,1));
        vq.push_back(mk(1,1,1,1, 7,30, 1,1, 0,0,2,1));
        // enable drop while snoozed, no re-ring
        vq.push_back(mk(1,1,0,0, 7,30, 0,1, 1,1,1,1));
        vq.push_back(mk(0,1,0,1, 7,30, 1,0, 0,2,1,0));
        vq.push_back(mk(0,0,0,0, 7,30, 1,0, 0,0,1,0));
        for (int i = 2; i <= 4; i++)
            vq.push_back(mk(1,1,0,0, 7,30, i,0, 0,0,1,0));
        // enable drop while ringing, disabled trigger, wrong hour
        vq.push_back(mk(1,1,0,0, 7,30, 0,3, 1,1,3,1));
        vq.push_back(mk(0,0,0,0, 7,30, 1,3, 0,0,3,1));
        vq.push_back(mk(1,0,0,0, 7,30, 0,2, 0,0,3,1));
        vq.push_back(mk(1,1,0,0, 8,30, 0,2, 0,0,3,1));

        foreach (vq[i]) begin
            drive(vq[i].tick, vq[i].en, vq[i].stop, vq[i].snz,
                  vq[i].h, vq[i].m, vq[i].s, vq[i].si);
            step();
            chk_all($sformatf("vec%0d", i),
                    vq[i].ea, vq[i].est, vq[i].esel, vq[i].eleft);
        end

        // asynchronous reset mid-ring
        drive(1, 1, 0, 0, 7, 30, 0, 2);
        step();
        chk("pre-rst alarm", int'(alarm), 1);
        drive(0, 1, 0, 0, 7, 30, 1, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst alarm", int'(alarm), 0);
        step();
        rst = 1'b0;
        chk_all("post-rst", 0, 0, 0, 0);
        drive(1, 0, 0, 0, 7, 30, 0, 1);
        step();
        chk_all("trig en low", 0, 0, 0, 0);

        // randomized traffic against the model
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            drive(($urandom % 3) == 0,
                  ($urandom % 24) != 0,
                  ($urandom % 25) == 0,
                  ($urandom % 6) == 0,
                  ($urandom % 4 == 0) ? int'($urandom % 32) : 7,
                  ($urandom % 4 == 0) ? int'($urandom % 60) : 30,
                  ($urandom % 3 == 0) ? 0 : int'($urandom_range(1, 59)),
                  int'($urandom % 4));
            model_step();
            step();
            chk_all($sformatf("rnd%0d", n),
                    (m_ph == 1) ? 1 : 0, m_ph, m_sel, m_left);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
